// File: rtl/vip_matrix_generate_nxn.sv
// vip_matrix_generate_nxn
//   Builds a KSIZE x KSIZE sliding pixel window from a raster video stream using a cascade of
//   KSIZE-1 line buffers. Taps that fall outside the frame are either zero-filled or filled by
//   replicating the nearest valid pixel. The output window lags the accepted pixel by two cycles.
//
// Parameters
//   DATA_W      pixel width (1..16)
//   KSIZE       window edge, odd, 3..7
//   IMG_W       maximum pixels per line (line-buffer depth)
//   BORDER_MODE 0 = zero fill, 1 = replicate nearest valid pixel
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   per_frame_vsync/href/clken   input frame, line and pixel-valid strobes
//   per_img_data                 input pixel, taken when href && clken
//   matrix_frame_vsync/href/clken  input strobes delayed by two cycles
//   matrix_data                  window, tap (r,c) at [(r*KSIZE+c)*DATA_W +: DATA_W]
//                                r=0 oldest line, c=0 oldest column
//   matrix_window_full           no tap of the emitted window is border-filled
//   line_overflow                sticky, a line in this frame exceeded IMG_W pixels
module vip_matrix_generate_nxn #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned KSIZE       = 5,
   parameter int unsigned IMG_W       = 1024,
   parameter int unsigned BORDER_MODE = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          per_frame_vsync,
   input  logic                          per_frame_href,
   input  logic                          per_frame_clken,
   input  logic [DATA_W-1:0]             per_img_data,
   output logic                          matrix_frame_vsync,
   output logic                          matrix_frame_href,
   output logic                          matrix_frame_clken,
   output logic [KSIZE*KSIZE*DATA_W-1:0] matrix_data,
   output logic                          matrix_window_full,
   output logic                          line_overflow
);

   localparam int unsigned NBUF = KSIZE - 1;
   localparam int unsigned CW   = $clog2(IMG_W + 1);
   localparam int unsigned AW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW   = $clog2(KSIZE);
   localparam logic [CW-1:0] IMG_W_C = CW'(IMG_W);
   localparam logic [RW-1:0] KM1_R   = RW'(KSIZE - 1);

   if ((KSIZE < 3) || (KSIZE > 7) || ((KSIZE % 2) != 1)) begin : g_bad_ksize
      $error("KSIZE must be odd and within 3..7");
   end
   if ((DATA_W < 1) || (DATA_W > 16) || (BORDER_MODE > 1) || (IMG_W < 1)) begin : g_bad_param
      $error("DATA_W must be 1..16, BORDER_MODE 0 or 1, IMG_W at least 1");
   end

   logic              vsync_q, href_q, ovf_q, ovf_d;
   logic              accept, vs_rise, href_fall, pix_ovf;
   logic [CW-1:0]     col_cnt_q, col_cnt_d, col_eff;
   logic [RW-1:0]     row_cnt_q, row_cnt_d, row_eff;
   logic [AW-1:0]     addr;
   logic [DATA_W-1:0] lbuf  [NBUF][IMG_W];
   logic [DATA_W-1:0] lb_rd [NBUF];

   logic [2:0]        sd1_q, sd2_q;
   logic              s1_valid_q, s1_ovf_q;
   logic [CW-1:0]     s1_col_cnt_q;
   logic [RW-1:0]     s1_row_cnt_q;
   logic [DATA_W-1:0] s1_col_q [KSIZE];

   logic [DATA_W-1:0] fill_px;
   logic [DATA_W-1:0] new_col [KSIZE];
   logic [DATA_W-1:0] win_q [KSIZE][KSIZE];
   logic [DATA_W-1:0] win_d [KSIZE][KSIZE];
   logic              full_q, full_d;

   // Stage 0: strobe edges, counters, line-buffer addressing
   always_comb begin
      accept    = per_frame_href && per_frame_clken;
      vs_rise   = per_frame_vsync && !vsync_q;
      href_fall = !per_frame_href && href_q;
      // A vsync rise clears the counters before a coincident pixel uses them
      col_eff   = vs_rise ? '0 : col_cnt_q;
      row_eff   = vs_rise ? '0 : row_cnt_q;
      pix_ovf   = accept && (col_eff >= IMG_W_C);
      addr      = (col_eff < IMG_W_C) ? col_eff[AW-1:0] : '0;

      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      if (vs_rise) begin
         col_cnt_d = '0;
         row_cnt_d = '0;
      end
      if (href_fall) begin
         col_cnt_d = '0;
         if (!vs_rise && (col_cnt_q != '0) && (row_cnt_q != KM1_R)) begin
            row_cnt_d = row_cnt_q + 1'b1;
         end
      end
      if (accept && (col_eff != IMG_W_C)) begin
         col_cnt_d = col_eff + 1'b1;
      end

      ovf_d = vs_rise ? 1'b0 : ovf_q;
      if (pix_ovf) begin
         ovf_d = 1'b1;
      end

      for (int k = 0; k < int'(NBUF); k++) begin
         lb_rd[k] = lbuf[k][addr];
      end
   end

   // Line buffers are not reset; row fill masks any stale contents
   always_ff @(posedge clk) begin
      if (accept && !pix_ovf) begin
         lbuf[0][addr] <= per_img_data;
         for (int k = 1; k < int'(NBUF); k++) begin
            lbuf[k][addr] <= lb_rd[k-1];
         end
      end
   end

   // Stage 2: border fill of the incoming column, then shift into the window
   always_comb begin
      fill_px = (BORDER_MODE == 1) ? s1_col_q[KM1_R - s1_row_cnt_q] : '0;
      for (int r = 0; r < int'(KSIZE); r++) begin
         new_col[r] = (s1_row_cnt_q >= RW'(int'(KSIZE) - 1 - r)) ? s1_col_q[r] : fill_px;
      end

      win_d = win_q;
      if (s1_valid_q) begin
         for (int r = 0; r < int'(KSIZE); r++) begin
            for (int c = 0; c < int'(KSIZE) - 1; c++) begin
               if (s1_col_cnt_q == '0) begin
                  win_d[r][c] = (BORDER_MODE == 1) ? new_col[r] : '0;
               end else begin
                  win_d[r][c] = win_q[r][c+1];
               end
            end
            win_d[r][KSIZE-1] = new_col[r];
         end
      end

      full_d = s1_valid_q && !s1_ovf_q && (s1_row_cnt_q == KM1_R) &&
               (int'(s1_col_cnt_q) >= int'(KSIZE) - 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         col_cnt_q    <= '0;
         row_cnt_q    <= '0;
         ovf_q        <= 1'b0;
         sd1_q        <= '0;
         sd2_q        <= '0;
         s1_valid_q   <= 1'b0;
         s1_ovf_q     <= 1'b0;
         s1_col_cnt_q <= '0;
         s1_row_cnt_q <= '0;
         full_q       <= 1'b0;
         for (int i = 0; i < int'(KSIZE); i++) begin
            s1_col_q[i] <= '0;
            for (int j = 0; j < int'(KSIZE); j++) begin
               win_q[i][j] <= '0;
            end
         end
      end else begin
         vsync_q    <= per_frame_vsync;
         href_q     <= per_frame_href;
         col_cnt_q  <= col_cnt_d;
         row_cnt_q  <= row_cnt_d;
         ovf_q      <= ovf_d;
         sd1_q      <= {per_frame_vsync, per_frame_href, per_frame_clken};
         sd2_q      <= sd1_q;
         s1_valid_q <= accept;
         if (accept) begin
            s1_col_q[KSIZE-1] <= per_img_data;
            for (int k = 0; k < int'(NBUF); k++) begin
               s1_col_q[int'(KSIZE) - 2 - k] <= lb_rd[k];
            end
            s1_ovf_q     <= pix_ovf;
            s1_col_cnt_q <= col_eff;
            s1_row_cnt_q <= row_eff;
         end
         full_q <= full_d;
         win_q  <= win_d;
      end
   end

   always_comb begin
      matrix_data = '0;
      for (int r = 0; r < int'(KSIZE); r++) begin
         for (int c = 0; c < int'(KSIZE); c++) begin
            matrix_data[(r*int'(KSIZE)+c)*int'(DATA_W) +: DATA_W] = win_q[r][c];
         end
      end
   end

   assign {matrix_frame_vsync, matrix_frame_href, matrix_frame_clken} = sd2_q;
   assign matrix_window_full = full_q;
   assign line_overflow      = ovf_q;

endmodule

// File: tb/tb_vip_matrix_generate_nxn.sv
// Bench for vip_matrix_generate_nxn: two 3x3 instances (zero fill and replicate fill, IMG_W=4)
// share one stimulus stream. Expected windows come from a direct frame model pushed into a
// scoreboard at drive time and popped when the DUT emits.
module tb_vip_matrix_generate_nxn;

   localparam int DW = 8;
   localparam int K  = 3;
   localparam int IW = 4;
   localparam int NB = K * K * DW;

   typedef struct packed {
      logic [NB-1:0] d0;
      logic [NB-1:0] d1;
      logic          full;
      logic          chk;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, vs, hr, ce;
   logic [DW-1:0] px;
   logic          mv0, mh0, mc0, full0, ovf0;
   logic          mv1, mh1, mc1, full1, ovf1;
   logic [NB-1:0] md0, md1;

   int            n_vec = 0;
   int            n_err = 0;
   exp_t          sb[$];
   logic [NB-1:0] cap0[$], cap1[$], ref0[$], ref1[$];
   logic          capf0[$], capf1[$];
   int            img [8][8];
   int            cur_row, cur_col;
   logic [2:0]    h1, h2;
   logic          rst_s;

   vip_matrix_generate_nxn #(
      .DATA_W(DW), .KSIZE(K), .IMG_W(IW), .BORDER_MODE(0)
   ) dut0 (
      .clk(clk), .rst(rst),
      .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_data(px),
      .matrix_frame_vsync(mv0), .matrix_frame_href(mh0), .matrix_frame_clken(mc0),
      .matrix_data(md0), .matrix_window_full(full0), .line_overflow(ovf0)
   );

   vip_matrix_generate_nxn #(
      .DATA_W(DW), .KSIZE(K), .IMG_W(IW), .BORDER_MODE(1)
   ) dut1 (
      .clk(clk), .rst(rst),
      .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_data(px),
      .matrix_frame_vsync(mv1), .matrix_frame_href(mh1), .matrix_frame_clken(mc1),
      .matrix_data(md1), .matrix_window_full(full1), .line_overflow(ovf1)
   );

   always #5 clk = ~clk;

   // Input strobes as they were two edges ago
   always @(posedge clk) begin
      rst_s <= rst;
      if (rst) begin
         h1 <= '0;
         h2 <= '0;
      end else begin
         h1 <= {vs, hr, ce};
         h2 <= h1;
      end
   end

   function automatic logic [NB-1:0] pack9(input int t0, input int t1, input int t2,
                                           input int t3, input int t4, input int t5,
                                           input int t6, input int t7, input int t8);
      int            t [9];
      logic [NB-1:0] v;
      t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3; t[4] = t4;
      t[5] = t5; t[6] = t6; t[7] = t7; t[8] = t8;
      v = '0;
      for (int i = 0; i < 9; i++) v[i*DW +: DW] = DW'(t[i]);
      return v;
   endfunction

   task automatic monitor();
      exp_t          e;
      logic [NB-1:0] prev0, prev1;
      prev0 = '0;
      prev1 = '0;
      forever begin
         @(negedge clk);
         if (rst_s === 1'b1) begin
            n_vec++;
            if ({md0, md1, mv0, mh0, mc0, mv1, mh1, mc1, full0, full1, ovf0, ovf1} !== '0) begin
               n_err++;
               $display("FAIL reset_outputs: got %h / %h full %b%b ovf %b%b, required all 0",
                        md0, md1, full0, full1, ovf0, ovf1);
            end
         end else if (rst_s === 1'b0) begin
            n_vec++;
            if ({mv0, mh0, mc0} !== h2 || {mv1, mh1, mc1} !== h2) begin
               n_err++;
               $display("FAIL strobe_delay: got %b / %b, required %b",
                        {mv0, mh0, mc0}, {mv1, mh1, mc1}, h2);
            end
            if (mc0 && mh0) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_output: got a window, required none pending");
               end else begin
                  e = sb.pop_front();
                  n_vec++;
                  if (full0 !== e.full || full1 !== e.full) begin
                     n_err++;
                     $display("FAIL window_full: got %b / %b, required %b", full0, full1, e.full);
                  end
                  if (e.chk) begin
                     n_vec++;
                     if (md0 !== e.d0) begin
                        n_err++;
                        $display("FAIL data_zero_fill: got %h, required %h", md0, e.d0);
                     end
                     n_vec++;
                     if (md1 !== e.d1) begin
                        n_err++;
                        $display("FAIL data_replicate: got %h, required %h", md1, e.d1);
                     end
                  end
                  cap0.push_back(md0);
                  cap1.push_back(md1);
                  capf0.push_back(full0);
                  capf1.push_back(full1);
               end
            end else begin
               n_vec++;
               if (full0 !== 1'b0 || full1 !== 1'b0 || md0 !== prev0 || md1 !== prev1) begin
                  n_err++;
                  $display("FAIL idle_hold: got %h / %h full %b%b, required %h / %h full 00",
                           md0, md1, full0, full1, prev0, prev1);
               end
            end
         end
         prev0 = md0;
         prev1 = md1;
      end
   endtask

   task automatic drive(input logic v, input logic h, input logic c, input logic [DW-1:0] d);
      @(negedge clk);
      vs = v;
      hr = h;
      ce = c;
      px = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic push_pixel(input int val, input logic with_vs);
      exp_t e;
      int   sr, sc, v0, v1;
      drive(with_vs, 1'b1, 1'b1, DW'(val));
      img[cur_row][cur_col] = val;
      e = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            sr = cur_row - (K - 1 - r);
            sc = cur_col - (K - 1 - c);
            v0 = (sr < 0 || sc < 0) ? 0 : img[sr][sc];
            v1 = img[(sr < 0) ? 0 : sr][(sc < 0) ? 0 : sc];
            e.d0[(r*K+c)*DW +: DW] = DW'(v0);
            e.d1[(r*K+c)*DW +: DW] = DW'(v1);
         end
      end
      e.full = (cur_row >= K - 1) && (cur_col >= K - 1) && (cur_col < IW);
      e.chk  = (cur_col < IW);
      sb.push_back(e);
      cur_col++;
   endtask

   task automatic gap();
      drive(1'b0, 1'b1, 1'b0, 8'hEE);
   endtask

   task automatic end_line();
      drive(1'b0, 1'b0, 1'b0, '0);
      if (cur_col > 0) cur_row++;
      cur_col = 0;
   endtask

   task automatic frame_start();
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, 1'b0, '0);
      cur_row = 0;
      cur_col = 0;
   endtask

   task automatic send_frame(input int h, input int w, input bit gaps, input bit vs_first);
      if (!vs_first) frame_start();
      else begin
         cur_row = 0;
         cur_col = 0;
      end
      for (int l = 0; l < h; l++) begin
         for (int p = 0; p < w; p++) begin
            if (gaps && (p % 2 == 1)) gap();
            push_pixel(l * w + p + 1, vs_first && l == 0 && p == 0);
         end
         end_line();
         idle(2);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain_timeout: %0d windows pending, required 0", sb.size());
      end
   endtask

   task automatic clear_caps();
      cap0.delete();
      cap1.delete();
      capf0.delete();
      capf1.delete();
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      n_vec++;
      if ({md0, md1, full0, full1, ovf0, ovf1, mc0, mc1} !== '0) begin
         n_err++;
         $display("FAIL test_reset: got %h / %h, required 0", md0, md1);
      end
      @(negedge clk);
      rst = 1'b0;
      vs  = 1'b0;
      hr  = 1'b0;
      ce  = 1'b0;
      px  = '0;
      idle(2);
   endtask

   task automatic check_frame_4x4(input string tag);
      logic [NB-1:0] want;
      n_vec++;
      if (cap0.size() != 16 || cap1.size() != 16) begin
         n_err++;
         $display("FAIL %s_count: got %0d / %0d windows, required 16", tag, cap0.size(),
                  cap1.size());
      end else begin
         want = pack9(1, 2, 3, 5, 6, 7, 9, 10, 11);
         n_vec++;
         if (cap0[10] !== want || capf0[10] !== 1'b1) begin
            n_err++;
            $display("FAIL %s_px11: got %h full %b, required %h full 1", tag, cap0[10],
                     capf0[10], want);
         end
         want = pack9(0, 0, 0, 0, 1, 2, 0, 5, 6);
         n_vec++;
         if (cap0[5] !== want) begin
            n_err++;
            $display("FAIL %s_px6_zero: got %h, required %h", tag, cap0[5], want);
         end
         want = pack9(1, 1, 1, 1, 1, 1, 1, 1, 1);
         n_vec++;
         if (cap1[0] !== want || capf1[0] !== 1'b0) begin
            n_err++;
            $display("FAIL %s_px1_repl: got %h full %b, required %h full 0", tag, cap1[0],
                     capf1[0], want);
         end
         want = pack9(1, 1, 2, 1, 1, 2, 5, 5, 6);
         n_vec++;
         if (cap1[5] !== want) begin
            n_err++;
            $display("FAIL %s_px6_repl: got %h, required %h", tag, cap1[5], want);
         end
      end
   endtask

   task automatic test_frame();
      clear_caps();
      send_frame(4, 4, 1'b0, 1'b0);
      drain();
      check_frame_4x4("frame");
      ref0 = cap0;
      ref1 = cap1;
   endtask

   task automatic test_clken_gaps();
      clear_caps();
      send_frame(4, 4, 1'b1, 1'b0);
      drain();
      n_vec++;
      if (cap0.size() != ref0.size() || cap1.size() != ref1.size()) begin
         n_err++;
         $display("FAIL gaps_count: got %0d windows, required %0d", cap0.size(), ref0.size());
      end else begin
         for (int i = 0; i < cap0.size(); i++) begin
            n_vec++;
            if (cap0[i] !== ref0[i] || cap1[i] !== ref1[i]) begin
               n_err++;
               $display("FAIL gaps_window_%0d: got %h / %h, required %h / %h", i, cap0[i],
                        cap1[i], ref0[i], ref1[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic exp_o;
      frame_start();
      for (int p = 0; p < 6; p++) begin
         push_pixel(p + 1, 1'b0);
         if (p > 0) begin
            exp_o = (p >= 5);
            n_vec++;
            if (ovf0 !== exp_o || ovf1 !== exp_o) begin
               n_err++;
               $display("FAIL overflow_after_px%0d: got %b%b, required %b", p, ovf0, ovf1,
                        exp_o);
            end
         end
      end
      end_line();
      n_vec++;
      if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_px6: got %b%b, required 1", ovf0, ovf1);
      end
      idle(2);
      for (int p = 0; p < 4; p++) push_pixel(11 + p, 1'b0);
      end_line();
      idle(2);
      drain();
      n_vec++;
      if (ovf0 !== 1'b1 || ovf1 !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_sticky: got %b%b, required 1", ovf0, ovf1);
      end
      frame_start();
      n_vec++;
      if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
         n_err++;
         $display("FAIL overflow_vsync_clear: got %b%b, required 0", ovf0, ovf1);
      end
      idle(2);
   endtask

   task automatic test_reset_midframe();
      frame_start();
      for (int l = 0; l < 2; l++) begin
         for (int p = 0; p < 4; p++) push_pixel(40 + l * 4 + p, 1'b0);
         end_line();
      end
      push_pixel(60, 1'b0);
      push_pixel(61, 1'b0);
      drive(1'b0, 1'b0, 1'b0, '0);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_vec++;
         if ({md0, md1, full0, full1, ovf0, ovf1, mv0, mh0, mc0} !== '0) begin
            n_err++;
            $display("FAIL midframe_reset_outputs: got %h / %h, required 0", md0, md1);
         end
      end
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      clear_caps();
      send_frame(4, 4, 1'b0, 1'b0);
      drain();
      check_frame_4x4("after_reset");
   endtask

   task automatic test_back_to_back();
      clear_caps();
      send_frame(3, 4, 1'b0, 1'b1);
      send_frame(2, 4, 1'b0, 1'b1);
      drain();
      n_vec++;
      if (cap0.size() != 20) begin
         n_err++;
         $display("FAIL back_to_back_count: got %0d windows, required 20", cap0.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      vs  = 1'b1;
      hr  = 1'b1;
      ce  = 1'b1;
      px  = 8'hAA;
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 0;
      cur_row = 0;
      cur_col = 0;
      fork
         monitor();
      join_none
      test_reset();
      test_frame();
      test_clken_gaps();
      test_overflow();
      test_reset_midframe();
      test_back_to_back();
      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
